// File: rtl/dcache_data_ram.sv
// dcache_data_ram: multi-way data array for the data cache.
// Each way holds 2^ADDR_WIDTH lines of DATA_WIDTH bits with byte-lane writes.
// A read returns every way at once so hit selection can happen downstream.
// The block adds three things on top of a plain byte-enable RAM:
// - a clear sequencer that zeroes the whole array, one index per cycle;
// - write-first forwarding when a read and a write hit the same index in one cycle;
// - an optional extra output register stage.
module dcache_data_ram #(
  parameter int WAYS           = 2,
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SIZE      = 8,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int WW            = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int BE_WIDTH      = DATA_WIDTH / BYTE_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic                       wr_en,
  input  logic [WW-1:0]              wr_way,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [BE_WIDTH-1:0]        wr_byte_en,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [WAYS*DATA_WIDTH-1:0] rd_data,
  output logic                       rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};
  localparam logic [WW:0] WAYS_W = (WW + 1)'(WAYS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  // Lane-wise merge: each enabled lane takes the new data.
  // Every disabled lane keeps the old data.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   lane_en
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (lane_en[b]) begin
        merged[b*BYTE_SIZE +: BYTE_SIZE] = new_word[b*BYTE_SIZE +: BYTE_SIZE];
      end else begin
        merged[b*BYTE_SIZE +: BYTE_SIZE] = old_word[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0]      mem [WAYS][DEPTH];
  state_t                     state_r;
  state_t                     state_next_s;
  logic [ADDR_WIDTH-1:0]      cnt_r;
  logic [ADDR_WIDTH-1:0]      cnt_next_s;
  logic                       busy_r;
  logic                       idle_s;
  logic                       wr_way_ok_s;
  logic                       do_wr_s;
  logic                       do_rd_s;
  logic                       fwd_addr_hit_s;
  logic [WAYS*DATA_WIDTH-1:0] rd_word_s;
  logic [WAYS*DATA_WIDTH-1:0] s1_data_r;
  logic                       s1_valid_r;

  assign idle_s         = (state_r == ST_IDLE);
  assign wr_way_ok_s    = ({1'b0, wr_way} < WAYS_W);
  assign do_wr_s        = idle_s && wr_en && wr_way_ok_s;
  assign do_rd_s        = idle_s && rd_en;
  assign fwd_addr_hit_s = do_wr_s && (wr_addr == rd_addr);
  assign busy           = busy_r;

  // Clear sequencer next state: sweep every index once, then return to idle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_next_s = ST_CLEAR;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = cnt_r;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST_INDEX) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_CLEAR;
          cnt_next_s   = cnt_r + 1'b1;
        end
      end
      default: begin
        state_next_s = RESET_STATE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Sequencer state, sweep counter and busy flag. busy is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
      cnt_r   <= '0;
      busy_r  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s == ST_CLEAR);
    end
  end

  // Array update. A clear zeroes all ways at the sweep index.
  // Otherwise a valid write updates only its enabled lanes. Contents are not reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!idle_s) begin
        mem[w][cnt_r] <= '0;
      end else if (do_wr_s && (wr_way == WW'(w))) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (wr_byte_en[b]) begin
            mem[w][wr_addr][b*BYTE_SIZE +: BYTE_SIZE] <= wr_data[b*BYTE_SIZE +: BYTE_SIZE];
          end
        end
      end
    end
  end

  // Read word for all ways. A same-index write in the same cycle is forwarded write-first.
  always_comb begin
    rd_word_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (fwd_addr_hit_s && (wr_way == WW'(w))) begin
        rd_word_s[w*DATA_WIDTH +: DATA_WIDTH] = merge_lanes(mem[w][rd_addr], wr_data, wr_byte_en);
      end else begin
        rd_word_s[w*DATA_WIDTH +: DATA_WIDTH] = mem[w][rd_addr];
      end
    end
  end

  // First read stage. It captures the word on an accepted read and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_r  <= '0;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= do_rd_s;
      if (do_rd_s) begin
        s1_data_r <= rd_word_s;
      end else begin
        s1_data_r <= s1_data_r;
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [WAYS*DATA_WIDTH-1:0] s2_data_r;
      logic                       s2_valid_r;

      // Optional output stage. It keeps moving during a clear, so reads in flight still finish.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data_r  <= '0;
          s2_valid_r <= 1'b0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end else begin
            s2_data_r <= s2_data_r;
          end
        end
      end

      assign rd_data  = s2_data_r;
      assign rd_valid = s2_valid_r;
    end else begin : g_no_out_reg
      assign rd_data  = s1_data_r;
      assign rd_valid = s1_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_dcache_data_ram.sv
// Scoreboard bench for dcache_data_ram. Two instances share one stimulus stream:
// - dut0: WAYS=2, OUTPUT_REG=0. It only sees writes to ways 0/1.
// - dut1: WAYS=3, OUTPUT_REG=1. It sees ways 0..3, where way 3 is invalid.
// The driver updates a plain array model and pushes the expected read words into queues.
// The monitor pops those words and compares them when rd_valid shows up.
module tb_dcache_data_ram;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr_req, wr_en, rd_en;
  logic [1:0]  wr_way;
  logic [8:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic        busy0, busy1, rv0, rv1;
  logic [63:0] rd0;
  logic [95:0] rd1;
  logic        wr_en0;
  logic        wr_way0;

  assign wr_en0  = wr_en && (wr_way < 2'd2);
  assign wr_way0 = wr_way[0];

  dcache_data_ram #(.WAYS(2), .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_SIZE(8),
                    .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
    .wr_en(wr_en0), .wr_way(wr_way0), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd0), .rd_valid(rv0));

  dcache_data_ram #(.WAYS(3), .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_SIZE(8),
                    .OUTPUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd1), .rd_valid(rv1));

  typedef struct {
    logic [95:0] data;
    int          cyc;
  } exp_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          clr_start = 0;
  logic [31:0] m0 [2][DEPTH];
  logic [31:0] m1 [3][DEPTH];
  exp_t        q0[$];
  exp_t        q1[$];
  logic [95:0] last0 = 96'h0;
  logic [95:0] last1 = 96'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // A clear covers 512 consecutive cycles starting at clr_start.
  function automatic bit busy_exp(int c);
    return (c >= clr_start) && (c < clr_start + DEPTH);
  endfunction

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) begin
      for (int w = 0; w < 2; w++) m0[w][a] = 32'h0;
      for (int w = 0; w < 3; w++) m1[w][a] = 32'h0;
    end
  endtask

  task automatic model_write(logic [1:0] way, logic [8:0] a, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        if (way < 2'd2) m0[way[0]][a][b*8 +: 8] = d[b*8 +: 8];
        if (way < 2'd3) m1[way][a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  // Drive one cycle of inputs. The model applies the write first, then the read (write-first).
  task automatic step(bit we, logic [1:0] way, logic [8:0] wa, logic [31:0] wd,
                      logic [3:0] be, bit re, logic [8:0] ra, bit clr);
    exp_t e;
    wr_en = we; wr_way = way; wr_addr = wa; wr_data = wd; wr_byte_en = be;
    rd_en = re; rd_addr = ra; clr_req = clr;
    if (rst_n && !busy_exp(cyc)) begin
      if (we) model_write(way, wa, wd, be);
      if (re) begin
        e.data = {32'h0, m0[1][ra], m0[0][ra]};
        e.cyc  = cyc + 1;
        q0.push_back(e);
        e.data = {m1[2][ra], m1[1][ra], m1[0][ra]};
        e.cyc  = cyc + 2;
        q1.push_back(e);
      end
      if (clr) begin
        clr_start = cyc + 1;
        model_zero();
      end
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 2'd0, 9'd0, 32'h0, 4'h0, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic rd(logic [8:0] a);
    step(1'b0, 2'd0, 9'd0, 32'h0, 4'h0, 1'b1, a, 1'b0);
  endtask

  task automatic wr(logic [1:0] way, logic [8:0] a, logic [31:0] d, logic [3:0] be);
    step(1'b1, way, a, d, be, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic wait_clear();
    while (busy_exp(cyc)) idle(1);
  endtask

  task automatic do_reset(int hold);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    last0 = 96'h0; last1 = 96'h0;
    idle(hold);
    rst_n = 1'b1;
    clr_start = cyc;
    model_zero();
  endtask

  task automatic random_phase(int n);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           9'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  // Monitor on the falling edge: busy, reset values, read data and latency, hold of rd_data.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (!rst_n) begin
        check("busy0_rst", 96'(busy0), 96'h1);
        check("busy1_rst", 96'(busy1), 96'h1);
        check("rv0_rst", 96'(rv0), 96'h0);
        check("rv1_rst", 96'(rv1), 96'h0);
        check("rd0_rst", {32'h0, rd0}, 96'h0);
        check("rd1_rst", rd1, 96'h0);
      end else begin
        check("busy0", 96'(busy0), 96'(busy_exp(cyc)));
        check("busy1", 96'(busy1), 96'(busy_exp(cyc)));
        if (rv0) begin
          if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rv0_unexpected cyc=%0d got=1 want=0", cyc);
          end else begin
            e = q0.pop_front();
            check("rd0_data", {32'h0, rd0}, e.data);
            check("rd0_latency", 96'(cyc), 96'(e.cyc));
            last0 = e.data;
          end
        end else begin
          check("rd0_hold", {32'h0, rd0}, last0);
          if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL rv0_missing cyc=%0d got=0 want=1", cyc);
            void'(q0.pop_front());
          end
        end
        if (rv1) begin
          if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rv1_unexpected cyc=%0d got=1 want=0", cyc);
          end else begin
            e = q1.pop_front();
            check("rd1_data", rd1, e.data);
            check("rd1_latency", 96'(cyc), 96'(e.cyc));
            last1 = e.data;
          end
        end else begin
          check("rd1_hold", rd1, last1);
          if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL rv1_missing cyc=%0d got=0 want=1", cyc);
            void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_way = 2'd0;
    wr_addr = 9'd0; rd_addr = 9'd0; wr_data = 32'h0; wr_byte_en = 4'h0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_start = cyc;

    // Clear after reset, then read the first, middle and last index.
    wait_clear();
    rd(9'd0); rd(9'd255); rd(9'd511); idle(3);

    // Byte-enable write into way 1.
    wr(2'd1, 9'd5, 32'hAABBCCDD, 4'b0101); rd(9'd5); idle(3);

    // Same-cycle forwarding.
    wr(2'd0, 9'd7, 32'h11223344, 4'b1111);
    step(1'b1, 2'd0, 9'd7, 32'hFFEEDDCC, 4'b1100, 1'b1, 9'd7, 1'b0);
    idle(3);

    // Back-to-back pipelined reads.
    for (int i = 1; i <= 4; i++) begin
      wr(2'd0, 9'(i), $urandom, 4'hF);
      wr(2'd1, 9'(i), $urandom, 4'hF);
      wr(2'd2, 9'(i), $urandom, 4'hF);
    end
    for (int i = 1; i <= 4; i++) rd(9'(i));
    idle(4);

    // Invalid way 3 is dropped. Way 2 is valid only in the 3-way instance.
    wr(2'd3, 9'd9, 32'hDEADBEEF, 4'hF);
    wr(2'd2, 9'd10, 32'h12345678, 4'hF);
    rd(9'd9); rd(9'd10); idle(3);

    random_phase(800);
    idle(3);

    // Clear request with a write and read in the same cycle. A later write mid-clear is ignored.
    step(1'b1, 2'd0, 9'd20, 32'hCAFEF00D, 4'hF, 1'b1, 9'd20, 1'b1);
    idle(2);
    step(1'b1, 2'd0, 9'd20, 32'h5A5A5A5A, 4'hF, 1'b1, 9'd20, 1'b0);
    wait_clear();
    rd(9'd20); rd(9'd7); idle(3);

    // Reset while a read is in flight.
    wr(2'd1, 9'd3, 32'h0BADF00D, 4'hF);
    rd(9'd3);
    do_reset(2);

    // Reset again at clear count 100. The clear then restarts and runs all 512 cycles.
    while (cyc < clr_start + 100) idle(1);
    do_reset(3);
    wait_clear();
    rd(9'd3); rd(9'd100); rd(9'($urandom_range(0, 511))); idle(3);

    random_phase(300);
    idle(6);
    check("drain_q0", 96'(q0.size()), 96'h0);
    check("drain_q1", 96'(q1.size()), 96'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_data_ram.md
# dcache_data_ram

Parametrised data-array RAM for the data cache: stores WAYS independent ways of 2^ADDR_WIDTH lines, each DATA_WIDTH bits, with per-byte write enables. Reads return all ways in parallel for hit selection downstream. Adds three functions to the single-way byte-enable SDP RAM:
- a hardware clear sequencer, so the cache can be flushed without software writes;
- same-cycle read/write forwarding;
- a selectable output register.

Sits between the cache controller (tag compare, refill, store path) and the bus/pixel-processing datapath.

## Interface
Parameters:
- WAYS, 2, number of ways; must be at least 1; way select width WW = max(1, clog2(WAYS))
- ADDR_WIDTH, 9, line index width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 32, bits per way entry; must be a multiple of BYTE_SIZE
- BYTE_SIZE, 8, bits per byte lane (8 or 9); BE_WIDTH = DATA_WIDTH/BYTE_SIZE
- OUTPUT_REG, 0, 1 adds one output register stage
- CLEAR_ON_RESET, 1, 1 runs a full clear automatically after reset release

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- clr_req  in  1  one-cycle pulse; starts a clear when IDLE
- busy  out  1  high while clearing
- wr_en  in  1  write strobe
- wr_way  in  WW  target way
- wr_addr  in  ADDR_WIDTH  write index
- wr_data  in  DATA_WIDTH  write data
- wr_byte_en  in  BE_WIDTH  byte lane enables; bit i covers data bits [i*BYTE_SIZE +: BYTE_SIZE]
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read index
- rd_data  out  WAYS*DATA_WIDTH  way w occupies bits [w*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  1  one-cycle pulse marking new rd_data

## Operation
- FSM has two states, IDLE and CLEAR.
- Reset state: CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset values: clear counter 0, busy = CLEAR_ON_RESET, rd_data all zero, rd_valid 0, pipeline valid flags 0. Array contents are not reset.
- CLEAR state:
  - Each cycle writes zero to every way, all lanes, at index = counter; counter increments by 1.
  - On the cycle counter = 2^ADDR_WIDTH-1, the FSM writes that index and moves to IDLE. busy deasserts the following cycle.
  - A clear takes exactly 2^ADDR_WIDTH cycles.
- During CLEAR, wr_en, rd_en and clr_req are ignored. rd_valid stays 0 and rd_data holds its value.
- IDLE + clr_req: the FSM enters CLEAR next cycle, with counter reset to 0 and busy = 1.
- If clr_req coincides with wr_en/rd_en in IDLE, the write and read are still performed that cycle.
- Write (IDLE, wr_en = 1):
  - Updates only lanes with wr_byte_en = 1, in way wr_way, at wr_addr.
  - Other lanes and other ways are unchanged.
  - wr_way >= WAYS: write is dropped.
- Read (IDLE, rd_en = 1): captures all ways at rd_addr.
- Forwarding: if rd_en and wr_en are in the same cycle with rd_addr = wr_addr, the result is write-first. In way wr_way, enabled lanes return wr_data; all other lanes and ways return the old contents.
- A write in a later cycle does not alter data already captured.
- rd_data holds its last value when no read completes.
- Both rd_en and wr_en low: no state change except the FSM.

## Timing
- Read latency from an rd_en cycle N:
  - OUTPUT_REG=0: rd_data and rd_valid at cycle N+1.
  - OUTPUT_REG=1: rd_data and rd_valid at cycle N+2.
- Reads are fully pipelined: back-to-back rd_en every cycle gives rd_valid every cycle.
- Write takes effect at the clk edge ending cycle N. A read at cycle N+1 of the same address returns the new data.
- With OUTPUT_REG=1, a read in flight when a clear starts still completes: its rd_valid appears on schedule.
- Asserting rst_n mid-clear or mid-read:
  - Outputs go to their reset values immediately.
  - In-flight reads are discarded.
  - After release, the clear restarts from index 0 if CLEAR_ON_RESET=1.
- busy timing: rises the cycle after clr_req is sampled. With CLEAR_ON_RESET=1 it is high from reset.

## Test plan
- Reset clear: defaults (WAYS=2, ADDR_WIDTH=9), rst_n released -> busy high for exactly 512 cycles. Then reads of indices 0, 255 and 511 return 64'h0 with rd_valid one cycle after rd_en.
- Byte-enable write: write way1 index 5, data 32'hAABBCCDD, be 4'b0101; then read index 5 -> way1 = 32'h00BB00DD, way0 = 0.
- Forwarding: index 7 way0 holds 32'h11223344. In the same cycle, write way0 index 7 with 32'hFFEEDDCC, be 4'b1100, and read index 7 -> way0 returns 32'hFFEE3344.
- Pipelined reads with OUTPUT_REG=1: rd_en on 4 consecutive cycles, indices 1..4 -> rd_valid on the 4 cycles starting 2 after the first, with data in order.
- Clear interplay:
  - clr_req, then wr_en at cycle 3 of the clear -> write ignored; after busy falls, the index reads 0.
  - rst_n asserted at clear count 100 -> the clear restarts at 0 and busy lasts a full 512 cycles after release.
- Invalid way: WAYS=3, wr_way=3, wr_en=1 -> no way changes on readback.
